// File: rtl/scarv_soc_intc_pkg.sv
// Shared constants and types for the SCARV SoC external interrupt controller.
//
// Register offsets are relative to the controller base address, word aligned.
// The response-state type is used by the bus responder in scarv_soc_intc.

package scarv_soc_intc_pkg;

   localparam logic [3:0]  INTC_OFF_PENDING = 4'h0;
   localparam logic [3:0]  INTC_OFF_ENABLE  = 4'h4;
   localparam logic [3:0]  INTC_OFF_CLAIM   = 4'h8;
   localparam logic [3:0]  INTC_OFF_CTRL    = 4'hC;

   localparam logic [31:0] INTC_CLAIM_NONE  = 32'hFFFF_FFFF;

   typedef enum logic {
      RSP_IDLE = 1'b0,
      RSP_WAIT = 1'b1
   } rsp_state_e;

endpackage

// File: rtl/scarv_soc_intc_prio.sv
// Lowest-index priority encoder for the interrupt controller.
//
// Ports:
//   active - in  - NUM_IRQ - masked pending sources
//   found  - out - 1       - at least one bit of active is set
//   index  - out - 5       - index of the lowest set bit (0 when none)

module scarv_soc_intc_prio #(
   parameter int NUM_IRQ = 8
) (
   input  logic [NUM_IRQ-1:0] active,
   output logic               found,
   output logic [4:0]         index
);

   // Scan from the top down so the lowest set bit is the last one written.
   always_comb begin
      found = 1'b0;
      index = 5'd0;
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         if (active[i]) begin
            found = 1'b1;
            index = 5'(i);
         end
      end
   end

endmodule

// File: rtl/scarv_soc_intc.sv
// SCARV SoC external interrupt controller.
//
// Latches and masks peripheral interrupt lines, drives the core complex
// external interrupt and its cause word, and exposes a 16-byte register
// window (PENDING, ENABLE, CLAIM, CTRL) on the core complex memory interface.
//
// Build option: define SCARV_SOC_INTC_EDGE_EN for rising-edge detection with
// sticky PENDING (cleared by write-1-to-clear or a CLAIM read). Without it,
// PENDING is a registered copy of irq.
//
// Ports:
//   f_clk         - in  - 1       - clock
//   g_resetn      - in  - 1       - asynchronous active-low reset
//   irq           - in  - NUM_IRQ - interrupt sources, active high
//   int_ext       - out - 1       - external interrupt to the core complex
//   int_ext_cause - out - 32      - winning source index while int_ext is high
//   memif_*       - core complex memory interface, responder side
//                   (req/wen/strb/addr/wdata/ack in; gnt/recv/error/rdata out)
//
// Response FSM:
//   state    | meaning
//   RSP_IDLE | no response outstanding
//   RSP_WAIT | response held on recv/rdata/error until acked

module scarv_soc_intc
   import scarv_soc_intc_pkg::*;
#(
   parameter logic [31:0] BASE    = 32'h1000_2000,
   parameter int          NUM_IRQ = 8
) (
   input  logic               f_clk,
   input  logic               g_resetn,
   input  logic [NUM_IRQ-1:0] irq,
   output logic               int_ext,
   output logic [31:0]        int_ext_cause,
   input  logic               memif_req,
   output logic               memif_gnt,
   input  logic               memif_wen,
   input  logic [3:0]         memif_strb,
   input  logic [31:0]        memif_addr,
   input  logic [31:0]        memif_wdata,
   output logic               memif_recv,
   input  logic               memif_ack,
   output logic               memif_error,
   output logic [31:0]        memif_rdata
);

   rsp_state_e         rsp_q, rsp_d;
   logic [31:0]        rdata_q, rdata_d;
   logic               error_q, error_d;
   logic [NUM_IRQ-1:0] pending_q, pending_d;
   logic [NUM_IRQ-1:0] enable_q, enable_d;
   logic               gen_q, gen_d;
   logic               int_ext_q, int_ext_d;
   logic [31:0]        cause_q, cause_d;

   logic               accept;
   logic [31:0]        offset;
   logic               addr_ok;
   logic [3:0]         reg_off;
   logic [31:0]        wmask;
   logic [31:0]        pend32, en32;
   logic [31:0]        enable_w;
   logic [31:0]        claim_val;
   logic [31:0]        rd_val;
   logic               wr_pending, wr_enable, wr_ctrl, rd_claim;
   logic [NUM_IRQ-1:0] active;
   logic               prio_found;
   logic [4:0]         prio_index;

   // Bus handshake and address decode. Subtracting BASE first lets a single
   // unsigned compare cover both ends of the window.
   assign memif_recv  = (rsp_q == RSP_WAIT);
   assign memif_gnt   = !memif_recv || memif_ack;
   assign memif_rdata = rdata_q;
   assign memif_error = error_q;
   assign accept      = memif_req && memif_gnt;

   assign offset  = memif_addr - BASE;
   assign addr_ok = (offset < 32'd16) && (memif_addr[1:0] == 2'b00);
   assign reg_off = offset[3:0];

   assign wr_pending = accept &&  memif_wen && addr_ok && (reg_off == INTC_OFF_PENDING);
   assign wr_enable  = accept &&  memif_wen && addr_ok && (reg_off == INTC_OFF_ENABLE);
   assign wr_ctrl    = accept &&  memif_wen && addr_ok && (reg_off == INTC_OFF_CTRL);
   assign rd_claim   = accept && !memif_wen && addr_ok && (reg_off == INTC_OFF_CLAIM);

   assign wmask = {{8{memif_strb[3]}}, {8{memif_strb[2]}},
                   {8{memif_strb[1]}}, {8{memif_strb[0]}}};

   always_comb begin
      pend32 = '0;
      en32   = '0;
      pend32[NUM_IRQ-1:0] = pending_q;
      en32[NUM_IRQ-1:0]   = enable_q;
   end

   assign enable_w = (en32 & ~wmask) | (memif_wdata & wmask);

   // One encoder serves both the CLAIM read and the registered cause.
   assign active = pending_q & enable_q;

   scarv_soc_intc_prio #(
      .NUM_IRQ (NUM_IRQ)
   ) u_prio (
      .active (active),
      .found  (prio_found),
      .index  (prio_index)
   );

   assign claim_val = prio_found ? {27'd0, prio_index} : INTC_CLAIM_NONE;

   always_comb begin
      rd_val = '0;
      if (addr_ok && !memif_wen) begin
         case (reg_off)
            INTC_OFF_PENDING: rd_val = pend32;
            INTC_OFF_ENABLE:  rd_val = en32;
            INTC_OFF_CLAIM:   rd_val = claim_val;
            INTC_OFF_CTRL:    rd_val = {31'd0, gen_q};
            default:          rd_val = '0;
         endcase
      end
   end

   always_comb begin
      rsp_d   = rsp_q;
      rdata_d = rdata_q;
      error_d = error_q;
      case (rsp_q)
         RSP_IDLE: begin
            if (accept) begin
               rsp_d   = RSP_WAIT;
               rdata_d = rd_val;
               error_d = !addr_ok;
            end
         end
         RSP_WAIT: begin
            // A new accept can only happen here when ack retires the old one.
            if (accept) begin
               rsp_d   = RSP_WAIT;
               rdata_d = rd_val;
               error_d = !addr_ok;
            end else if (memif_ack) begin
               rsp_d   = RSP_IDLE;
               rdata_d = '0;
               error_d = 1'b0;
            end
         end
         default: begin
            rsp_d   = RSP_IDLE;
            rdata_d = '0;
            error_d = 1'b0;
         end
      endcase
   end

   assign enable_d  = wr_enable ? enable_w[NUM_IRQ-1:0] : enable_q;
   assign gen_d     = (wr_ctrl && memif_strb[0]) ? memif_wdata[0] : gen_q;
   assign int_ext_d = gen_q && prio_found;
   assign cause_d   = int_ext_d ? claim_val : 32'd0;

`ifdef SCARV_SOC_INTC_EDGE_EN
   logic [NUM_IRQ-1:0] irq_prev_q;
   logic [NUM_IRQ-1:0] irq_rise;
   logic [NUM_IRQ-1:0] w1c_mask;
   logic [NUM_IRQ-1:0] claim_mask;
   logic [31:0]        w1c_w;
   logic               unused_ok;

   assign irq_rise = irq & ~irq_prev_q;
   assign w1c_w    = memif_wdata & wmask;
   assign w1c_mask = wr_pending ? w1c_w[NUM_IRQ-1:0] : '0;

   always_comb begin
      claim_mask = '0;
      for (int i = 0; i < NUM_IRQ; i++) begin
         claim_mask[i] = rd_claim && prio_found && (prio_index == 5'(i));
      end
   end

   // New edges are ORed in after the clears so a coincident set wins.
   assign pending_d = (pending_q & ~(w1c_mask | claim_mask)) | irq_rise;

   always_ff @(posedge f_clk or negedge g_resetn) begin
      if (!g_resetn) begin
         irq_prev_q <= '0;
      end else begin
         irq_prev_q <= irq;
      end
   end

   assign unused_ok = ^{enable_w, w1c_w};
`else
   logic unused_ok;

   // Level mode: PENDING writes and CLAIM side effects are accepted silently.
   assign pending_d = irq;
   assign unused_ok = ^{enable_w, wr_pending, rd_claim};
`endif

   always_ff @(posedge f_clk or negedge g_resetn) begin
      if (!g_resetn) begin
         rsp_q     <= RSP_IDLE;
         rdata_q   <= '0;
         error_q   <= 1'b0;
         pending_q <= '0;
         enable_q  <= '0;
         gen_q     <= 1'b0;
         int_ext_q <= 1'b0;
         cause_q   <= '0;
      end else begin
         rsp_q     <= rsp_d;
         rdata_q   <= rdata_d;
         error_q   <= error_d;
         pending_q <= pending_d;
         enable_q  <= enable_d;
         gen_q     <= gen_d;
         int_ext_q <= int_ext_d;
         cause_q   <= cause_d;
      end
   end

   assign int_ext       = int_ext_q;
   assign int_ext_cause = cause_q;

endmodule

// File: tb/tb_scarv_soc_intc.sv
// Directed self-checking bench for scarv_soc_intc (default parameters).
// Expectations that differ between level and edge builds are selected with
// SCARV_SOC_INTC_EDGE_EN.

module tb_scarv_soc_intc;

   localparam logic [31:0] BASE    = 32'h1000_2000;
   localparam logic [31:0] A_PEND  = BASE + 32'h0;
   localparam logic [31:0] A_EN    = BASE + 32'h4;
   localparam logic [31:0] A_CLAIM = BASE + 32'h8;
   localparam logic [31:0] A_CTRL  = BASE + 32'hC;

`ifdef SCARV_SOC_INTC_EDGE_EN
   localparam logic [31:0] EXP_PEND_AFTER_DROP = 32'h0000_0004;
`else
   localparam logic [31:0] EXP_PEND_AFTER_DROP = 32'h0000_0000;
`endif

   logic        f_clk;
   logic        g_resetn;
   logic [7:0]  irq;
   logic        int_ext;
   logic [31:0] int_ext_cause;
   logic        req, gnt, wen, recv, ack, error;
   logic [3:0]  strb;
   logic [31:0] addr, wdata, rdata;

   int n_vec = 0;
   int n_err = 0;

   scarv_soc_intc #(
      .BASE    (BASE),
      .NUM_IRQ (8)
   ) dut (
      .f_clk         (f_clk),
      .g_resetn      (g_resetn),
      .irq           (irq),
      .int_ext       (int_ext),
      .int_ext_cause (int_ext_cause),
      .memif_req     (req),
      .memif_gnt     (gnt),
      .memif_wen     (wen),
      .memif_strb    (strb),
      .memif_addr    (addr),
      .memif_wdata   (wdata),
      .memif_recv    (recv),
      .memif_ack     (ack),
      .memif_error   (error),
      .memif_rdata   (rdata)
   );

   initial f_clk = 1'b0;
   always #5 f_clk = ~f_clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
      end
   endtask

   // Starts at a negedge, returns at the negedge after the accept edge with
   // ack left high so the response retires on the following edge.
   task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, output logic [31:0] rd, output logic er);
      req = 1'b1; wen = w; addr = a; wdata = d; strb = s; ack = 1'b1;
      #1;
      chk("gnt_ready", {31'd0, gnt}, 32'd1);
      @(posedge f_clk);
      @(negedge f_clk);
      req = 1'b0; wen = 1'b0;
      chk("recv_after_accept", {31'd0, recv}, 32'd1);
      rd = rdata;
      er = error;
   endtask

   task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
      logic [31:0] d;
      logic        e;
      xfer(1'b0, a, 32'd0, 4'hF, d, e);
      chk({tag, "_data"}, d, exp);
      chk({tag, "_err"}, {31'd0, e}, 32'd0);
   endtask

   task automatic wr_chk(input string tag, input logic [31:0] a, input logic [31:0] v,
                         input logic [3:0] s, input logic exp_err);
      logic [31:0] d;
      logic        e;
      xfer(1'b1, a, v, s, d, e);
      chk({tag, "_err"}, {31'd0, e}, {31'd0, exp_err});
      chk({tag, "_rdata"}, d, 32'd0);
   endtask

   task automatic err_rd(input string tag, input logic [31:0] a);
      logic [31:0] d;
      logic        e;
      xfer(1'b0, a, 32'd0, 4'hF, d, e);
      chk({tag, "_err"}, {31'd0, e}, 32'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed no finish, expected finish before 100us");
      $fatal(1, "watchdog");
   end

   initial begin
      g_resetn = 1'b0; irq = '0; req = 1'b0; wen = 1'b0; strb = '0;
      addr = '0; wdata = '0; ack = 1'b1;
      repeat (3) @(negedge f_clk);
      chk("rst_gnt",   {31'd0, gnt},     32'd1);
      chk("rst_recv",  {31'd0, recv},    32'd0);
      chk("rst_error", {31'd0, error},   32'd0);
      chk("rst_rdata", rdata,            32'd0);
      chk("rst_int",   {31'd0, int_ext}, 32'd0);
      chk("rst_cause", int_ext_cause,    32'd0);
      g_resetn = 1'b1;
      @(negedge f_clk);

      rd_chk("rst_enable",  A_EN,   32'd0);
      rd_chk("rst_pending", A_PEND, 32'd0);
      rd_chk("rst_ctrl",    A_CTRL, 32'd0);
      chk("rst_int_after_reads", {31'd0, int_ext}, 32'd0);

      // Configuration and byte-lane masking.
      wr_chk("wr_enable", A_EN, 32'h0000_0005, 4'hF, 1'b0);
      wr_chk("wr_ctrl",   A_CTRL, 32'h0000_0001, 4'hF, 1'b0);
      wr_chk("wr_enable_lane0_off", A_EN, 32'h0000_00FF, 4'b1110, 1'b0);
      rd_chk("enable_readback", A_EN, 32'h0000_0005);
      rd_chk("ctrl_readback",   A_CTRL, 32'h0000_0001);

      // irq[2] rises: PENDING at n+1, int_ext at n+2.
      irq = 8'h04;
      @(negedge f_clk);
      chk("irq2_int_n1", {31'd0, int_ext}, 32'd0);
      @(negedge f_clk);
      chk("irq2_int_n2",   {31'd0, int_ext}, 32'd1);
      chk("irq2_cause_n2", int_ext_cause,    32'd2);
      rd_chk("irq2_pending", A_PEND, 32'h0000_0004);
      irq = 8'h00;
      repeat (2) @(negedge f_clk);
      rd_chk("pending_after_drop", A_PEND, EXP_PEND_AFTER_DROP);

      // Two enabled sources, claimed lowest first.
`ifdef SCARV_SOC_INTC_EDGE_EN
      irq = 8'h01;
      @(negedge f_clk);
      irq = 8'h00;
`else
      irq = 8'h05;
      @(negedge f_clk);
`endif
      @(negedge f_clk);
      chk("two_src_int",   {31'd0, int_ext}, 32'd1);
      chk("two_src_cause", int_ext_cause,    32'd0);
      rd_chk("claim1", A_CLAIM, 32'd0);
`ifndef SCARV_SOC_INTC_EDGE_EN
      irq = 8'h04;
`endif
      @(negedge f_clk);
      rd_chk("pend_after_claim1", A_PEND, 32'h0000_0004);
      rd_chk("claim2", A_CLAIM, 32'd2);
      irq = 8'h00;
      @(negedge f_clk);
      rd_chk("claim3", A_CLAIM, 32'hFFFF_FFFF);
      repeat (2) @(negedge f_clk);
      chk("claim_int_fall",   {31'd0, int_ext}, 32'd0);
      chk("claim_cause_zero", int_ext_cause,    32'd0);

      // Bad addresses: error, no side effect.
      err_rd("rd_base_p10", BASE + 32'h10);
      err_rd("rd_base_p2",  BASE + 32'h2);
      wr_chk("wr_base_p14", BASE + 32'h14, 32'h0000_00FF, 4'hF, 1'b1);
      wr_chk("wr_base_p5",  BASE + 32'h5,  32'h0000_00FF, 4'hF, 1'b1);
      wr_chk("wr_base_pd",  BASE + 32'hD,  32'h0000_0000, 4'hF, 1'b1);
      rd_chk("enable_after_bad", A_EN,   32'h0000_0005);
      rd_chk("ctrl_after_bad",   A_CTRL, 32'h0000_0001);
      wr_chk("wr_claim_ignored", A_CLAIM, 32'hFFFF_FFFF, 4'hF, 1'b0);
      rd_chk("enable_after_claim_wr", A_EN, 32'h0000_0005);

      // Backpressure: response held while ack is low, then back-to-back.
      req = 1'b1; wen = 1'b0; addr = A_EN; strb = 4'hF; ack = 1'b0;
      @(negedge f_clk);
      req = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("hold_recv",  {31'd0, recv}, 32'd1);
         chk("hold_rdata", rdata,         32'h0000_0005);
         chk("hold_gnt",   {31'd0, gnt},  32'd0);
         @(negedge f_clk);
      end
      ack = 1'b1; req = 1'b1; addr = A_CTRL;
      #1;
      chk("b2b_gnt", {31'd0, gnt}, 32'd1);
      @(negedge f_clk);
      req = 1'b0;
      chk("b2b_recv",  {31'd0, recv}, 32'd1);
      chk("b2b_rdata", rdata,         32'h0000_0001);
      @(negedge f_clk);
      chk("b2b_idle", {31'd0, recv}, 32'd0);

      // Edge on irq[1] coincident with a W1C of bit 1: set wins.
      irq = 8'h02;
      wr_chk("w1c_coincident", A_PEND, 32'h0000_0002, 4'hF, 1'b0);
      rd_chk("pend_coincident", A_PEND, 32'h0000_0002);
      wr_chk("wr_enable7", A_EN, 32'h0000_0007, 4'hF, 1'b0);
      @(negedge f_clk);
      chk("irq1_int",   {31'd0, int_ext}, 32'd1);
      chk("irq1_cause", int_ext_cause,    32'd1);
      wr_chk("gen_off", A_CTRL, 32'h0000_0000, 4'hF, 1'b0);
      @(negedge f_clk);
      chk("gen_off_int",   {31'd0, int_ext}, 32'd0);
      chk("gen_off_cause", int_ext_cause,    32'd0);
      wr_chk("gen_on", A_CTRL, 32'h0000_0001, 4'hF, 1'b0);
      @(negedge f_clk);
      chk("gen_on_int", {31'd0, int_ext}, 32'd1);

      // Reset with a response outstanding.
      req = 1'b1; wen = 1'b0; addr = A_EN; strb = 4'hF; ack = 1'b0;
      @(negedge f_clk);
      req = 1'b0;
      chk("pre_reset_recv", {31'd0, recv}, 32'd1);
      #2;
      g_resetn = 1'b0;
      #1;
      chk("mid_reset_recv",  {31'd0, recv},    32'd0);
      chk("mid_reset_int",   {31'd0, int_ext}, 32'd0);
      chk("mid_reset_gnt",   {31'd0, gnt},     32'd1);
      chk("mid_reset_cause", int_ext_cause,    32'd0);
      @(negedge f_clk);
      irq = 8'h00; ack = 1'b1;
      g_resetn = 1'b1;
      @(negedge f_clk);
      rd_chk("post_reset_enable", A_EN,   32'd0);
      rd_chk("post_reset_ctrl",   A_CTRL, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
